// File: rtl/nios_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with valid/ready handshake, sideband tag and flush.
// Define NIOS_MULT_PIPE_HI_EN to build the hi*hi partial product and the signed upper half.
module nios_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              signed1,
    input  logic              signed2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int H   = DATA_W / 2;
    localparam int PW2 = 2 * DATA_W;
    localparam int NS  = STAGES - 1;
`ifdef NIOS_MULT_PIPE_HI_EN
    localparam int PPW = DATA_W + 2;
    localparam int PB  = DATA_W + 3 * PPW;
`else
    localparam int PB  = 3 * DATA_W;
`endif

    logic              advance;
    logic [PB-1:0]     pp_d;
    logic [PB-1:0]     pp_q    [NS];
    logic              valid_q [NS];
    logic [TAG_W-1:0]  tag_q   [NS];
    logic [DATA_W-1:0] prod_lo;
    logic [DATA_W-1:0] prod_hi;

`ifdef NIOS_MULT_PIPE_HI_EN
    // Upper halves are sign-extended to H+1 bits so every cross product is a plain signed multiply.
    logic signed [H:0]     a_hi, a_lo, b_hi, b_lo;
    logic [DATA_W-1:0]     pp_ll;
    logic signed [PPW-1:0] pp_lh, pp_hl, pp_hh;
    logic [DATA_W-1:0]     s_ll;
    logic signed [PPW-1:0] s_lh, s_hl, s_hh;
    logic signed [PW2-1:0] sum;

    always_comb begin
        a_hi  = {signed1 & src1[DATA_W-1], src1[DATA_W-1:H]};
        a_lo  = {1'b0, src1[H-1:0]};
        b_hi  = {signed2 & src2[DATA_W-1], src2[DATA_W-1:H]};
        b_lo  = {1'b0, src2[H-1:0]};
        pp_ll = DATA_W'(src1[H-1:0]) * DATA_W'(src2[H-1:0]);
        pp_lh = PPW'(a_lo) * PPW'(b_hi);
        pp_hl = PPW'(a_hi) * PPW'(b_lo);
        pp_hh = PPW'(a_hi) * PPW'(b_hi);
        pp_d  = {pp_ll, pp_lh, pp_hl, pp_hh};
    end

    always_comb begin
        {s_ll, s_lh, s_hl, s_hh} = pp_q[NS-1];
        sum = $signed({{DATA_W{1'b0}}, s_ll})
            + (PW2'(s_lh) <<< H)
            + (PW2'(s_hl) <<< H)
            + (PW2'(s_hh) <<< DATA_W);
        prod_lo = sum[DATA_W-1:0];
        prod_hi = sum[PW2-1:DATA_W];
    end
`else
    // The low half of a product does not depend on operand signedness, so the sign bits are unused.
    logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl;
    logic [DATA_W-1:0] s_ll, s_lh, s_hl;
    logic              unused_sign;

    assign unused_sign = signed1 ^ signed2;

    always_comb begin
        pp_ll = DATA_W'(src1[H-1:0])      * DATA_W'(src2[H-1:0]);
        pp_lh = DATA_W'(src1[H-1:0])      * DATA_W'(src2[DATA_W-1:H]);
        pp_hl = DATA_W'(src1[DATA_W-1:H]) * DATA_W'(src2[H-1:0]);
        pp_d  = {pp_ll, pp_lh, pp_hl};
    end

    always_comb begin
        {s_ll, s_lh, s_hl} = pp_q[NS-1];
        prod_lo = s_ll + ((s_lh + s_hl) << H);
        prod_hi = '0;
    end
`endif

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;

    // Whole pipe moves as one unit; flush only drops valid bits so stale data is harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                valid_q[i] <= 1'b0;
                pp_q[i]    <= '0;
                tag_q[i]   <= '0;
            end
            out_valid <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            for (int i = 0; i < NS; i++) begin
                valid_q[i] <= 1'b0;
            end
            out_valid <= 1'b0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            pp_q[0]    <= pp_d;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < NS; i++) begin
                valid_q[i] <= valid_q[i-1];
                pp_q[i]    <= pp_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
            out_valid <= valid_q[NS-1];
            result_lo <= prod_lo;
            result_hi <= prod_hi;
            out_tag   <= tag_q[NS-1];
        end
    end

endmodule

// File: doc/nios_mult_pipe.md
NIOS_MULT_PIPE -- requirements
Module: nios_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; even, 16..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in cycles; 2..4.
REQ-003 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each operation.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-008 src1, src2  input  DATA_W each  operands.
REQ-009 signed1, signed2  input  1 each  operand is two's-complement (1) or unsigned (0).
REQ-010 in_tag  input  TAG_W  sideband tag, returned unchanged.
REQ-011 flush  input  1  synchronous discard of all in-flight operations.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 result_lo, result_hi  output  DATA_W each  low/high halves of the product.
REQ-015 out_tag  output  TAG_W  tag of the presented result.

Function
REQ-016 Product SHALL be the exact 2*DATA_W-bit product of src1 and src2, each interpreted per its signed bit; {result_hi,result_lo} = product.
REQ-017 Stage 1 SHALL register half-width partial products (lo*lo, lo*hi, hi*lo, hi*hi); the last stage SHALL register the shifted sum; middle stages are delay registers.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready stays high.
REQ-019 Throughput SHALL be one operation per cycle with no bubbles while out_ready is high.
REQ-020 Stall rule: in_ready = !out_valid || out_ready; when in_ready is low every stage SHALL hold, including data, valid and tag.
REQ-021 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-022 Outputs SHALL remain stable while out_valid && !out_ready.
REQ-023 flush SHALL clear every stage valid bit at the next edge; out_valid is 0 the cycle after flush.
REQ-024 flush SHALL force in_ready low; flush with in_valid in the same cycle drops the input.
REQ-025 Stage with valid=0 SHALL still advance when not stalled (bubble collapse not required).

Reset
REQ-026 reset_n low SHALL asynchronously clear all stage valid, data and tag registers to 0.
REQ-027 During and after reset: out_valid=0, result_lo=0, result_hi=0, out_tag=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; first accepted operation after release completes in STAGES cycles.

Configuration
REQ-029 Macro NIOS_MULT_PIPE_HI_EN defined: hi*hi partial product and sign corrections SHALL be built; result_hi per REQ-016.
REQ-030 Macro undefined: only lo*lo, lo*hi, hi*lo SHALL be built; result_hi SHALL be constant 0; result_lo unchanged (sign-independent); signed1/signed2 ignored.

Verification
REQ-031 DATA_W=32, STAGES=2, unsigned, 0xFFFFFFFF*0xFFFFFFFF -> two cycles later out_valid=1, result_hi=0xFFFFFFFE, result_lo=0x00000001.
REQ-032 Signed both, 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> result_hi=0x00000000, result_lo=0x00000001; signed1 only, 0xFFFFFFFF*0x00000002 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE.
REQ-033 Back-to-back 4 ops tags 1..4, out_ready low 3 cycles mid-stream -> in_ready low while stalled, results emerge in tag order 1,2,3,4, none lost.
REQ-034 Two ops in flight, flush pulsed with in_valid=1 -> out_valid=0 next cycle, no result for any of the three, next accepted op completes normally.
REQ-035 reset_n pulsed low with full pipeline -> outputs 0 immediately, in_ready=1, no stale result after release.
REQ-036 Macro undefined, 0x00010000*0x00010000 -> result_lo=0x00000000, result_hi=0; 0x0000FFFF*0x0000FFFF -> result_lo=0xFFFE0001.
